// File: rtl/dense_argmax_reader_pkg.sv
// Shared definitions for the dense-layer argmax reader: FSM state encoding
// and the index-width helper used to size addresses and class indices.
package dense_argmax_reader_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StIssue = ISSUE,
    StDrain = DRAIN,
    StDone  = DONE
  } state_e;

  // clog2 with a floor of 1 so a single-class build still has a 1-bit index.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dense_argmax_reader_if.sv
// Bus bundle between the argmax reader, the shared outputs RAM and the
// result/display logic. classOneHot exists only when ARGMAX_ONEHOT_EN is defined.
interface dense_argmax_reader_if #(
  parameter int unsigned OUT_COUNT = 10,
  parameter int unsigned DATA_SIZE = 16
);
  localparam int unsigned IDX_W = dense_argmax_reader_pkg::idxWidth(OUT_COUNT);

  logic                 start;
  logic                 ram_rd;
  logic [IDX_W-1:0]     ram_adr;
  logic [DATA_SIZE-1:0] ram_dataOut;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     classOut;
  logic [DATA_SIZE-1:0] maxScore;
`ifdef ARGMAX_ONEHOT_EN
  logic [OUT_COUNT-1:0] classOneHot;
`endif

  // Reader side: drives the RAM read port and the result.
  modport master (
    input  start, ram_dataOut,
    output ram_rd, ram_adr, busy, done, classOut, maxScore
`ifdef ARGMAX_ONEHOT_EN
    , output classOneHot
`endif
  );

  // Environment side: RAM and result consumer.
  modport slave (
    output start, ram_dataOut,
    input  ram_rd, ram_adr, busy, done, classOut, maxScore
`ifdef ARGMAX_ONEHOT_EN
    , input classOneHot
`endif
  );

endinterface

// File: rtl/dense_argmax_reader_loop_counter.sv
// LoopCounter: saturating address counter. clr forces zero, en advances it
// until COUNT-1, where it holds; last flags the final address.
module LoopCounter
  import dense_argmax_reader_pkg::*;
#(
  parameter int unsigned COUNT = 10,
  localparam int unsigned W    = idxWidth(COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cntQ;

  assign cnt  = cntQ;
  assign last = (cntQ == W'(COUNT - 1));

  // Count register; never runs past COUNT-1 so out-of-range addresses cannot appear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cntQ <= '0;
    end else if (en && !last) begin
      cntQ <= cntQ + W'(1);
    end
  end

endmodule

// File: rtl/dense_argmax_reader.sv
// dense_argmax_reader: scans the dense layer's outputs RAM once per start and
// reports the index and value of the largest signed score (lowest index wins ties).
// Optional feature macro: ARGMAX_ONEHOT_EN adds a registered one-hot class output.
module dense_argmax_reader
  import dense_argmax_reader_pkg::*;
#(
  parameter int unsigned OUT_COUNT = 10,
  parameter int unsigned DATA_SIZE = 16,
  localparam int unsigned IDX_W    = idxWidth(OUT_COUNT)
) (
  input logic                    clk,
  input logic                    rst,
  dense_argmax_reader_if.master  bus
);

  state_e               stateQ, stateD;
  logic                 accept;
  logic [IDX_W-1:0]     cnt;
  logic                 cntLast;
  logic                 vldQ;
  logic [IDX_W-1:0]     tagQ;
  logic                 update;
  logic [IDX_W-1:0]     classQ;
  logic [DATA_SIZE-1:0] maxScoreQ;

  assign accept = (stateQ == StIdle) && bus.start;

  LoopCounter #(
    .COUNT (OUT_COUNT)
  ) u_addrCnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stateQ == StIssue),
    .clr  (accept),
    .cnt  (cnt),
    .last (cntLast)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    stateD      = stateQ;
    bus.ram_rd  = 1'b0;
    bus.ram_adr = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) stateD = StIssue;
      end
      StIssue: begin
        bus.ram_rd  = 1'b1;
        bus.ram_adr = cnt;
        bus.busy    = 1'b1;
        if (cntLast) stateD = StDrain;
      end
      StDrain: begin
        bus.busy = 1'b1;
        stateD   = StDone;
      end
      StDone: begin
        bus.done = 1'b1;
        stateD   = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Read-tracking pipeline: valid/tag line up with ram_dataOut one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vldQ <= 1'b0;
      tagQ <= '0;
    end else begin
      vldQ <= (stateQ == StIssue);
      tagQ <= cnt;
    end
  end

  // Index 0 is always the first read of a scan, so it loads unconditionally.
  assign update = vldQ &&
                  ((tagQ == '0) || ($signed(bus.ram_dataOut) > $signed(maxScoreQ)));

  // Running maximum; held between scans until the next first compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      classQ    <= '0;
      maxScoreQ <= '0;
    end else if (update) begin
      classQ    <= tagQ;
      maxScoreQ <= bus.ram_dataOut;
    end
  end

  assign bus.classOut = classQ;
  assign bus.maxScore = maxScoreQ;

`ifdef ARGMAX_ONEHOT_EN
  logic [OUT_COUNT-1:0] oneHotQ;

  // One-hot mirror of classOut, written on the same compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      oneHotQ <= '0;
    end else if (update) begin
      oneHotQ <= OUT_COUNT'(1) << tagQ;
    end
  end

  assign bus.classOneHot = oneHotQ;
`endif

endmodule
